keypad_key_fifo: RTL and testbench

Downstream consumer of the keypad scanner. Snoops the scanner's `row` drive and the keypad `col` lines to capture the pressed key position. On the scanner's one-cycle `en` commit pulse it decodes that position to a 4-bit hex key code and pushes the code into a small FIFO. The FIFO is drained by the MCU-facing interface (SPI/display logic) through a valid/ready handshake.

---
 rtl/keypad_key_fifo.sv | 165 ++++++++++++++++
 tb/tb_keypad_key_fifo.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/keypad_key_fifo.sv
// keypad_key_fifo
//   Snoops the keypad scanner's row drive and the column sense lines to
//   capture the pressed key, decodes it to a hex key code on the scanner's
//   commit pulse and queues the code for the MCU-side consumer.
//
// Ports
//   clk        system clock, all state on posedge
//   rst_n      asynchronous active-low reset
//   row        one-hot row drive from scanner
//   col        keypad column sense, active-high
//   key_en     scanner commit pulse, one cycle per press
//   key_valid  FIFO non-empty
//   key_code   code at FIFO head, valid when key_valid
//   key_ready  consumer accepts head when key_valid & key_ready
//   count      current FIFO occupancy (0..DEPTH)
//   overflow   sticky: commit dropped because FIFO was full
//   bad_key    sticky: commit dropped because capture was not one-hot
//   clr_flags  synchronous clear of overflow and bad_key
//
// Capture FSM
//   state    | meaning
//   IDLE     | waiting for any column to go active
//   HELD     | row/col captured and frozen, waiting for commit
//   WAIT_REL | committed, waiting for all columns to release
module keypad_key_fifo #(
  parameter  int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [3:0]       row,
  input  logic [3:0]       col,
  input  logic             key_en,
  output logic             key_valid,
  output logic [3:0]       key_code,
  input  logic             key_ready,
  output logic [PTR_W:0]   count,
  output logic             overflow,
  output logic             bad_key,
  input  logic             clr_flags
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    HELD     = 2'd1,
    WAIT_REL = 2'd2
  } state_t;

  localparam logic [PTR_W:0] DEPTH_C = (PTR_W+1)'(DEPTH);

  state_t            state, state_nx;
  logic [3:0]        cap_row, cap_col;
  logic              zero_seen;
  logic              cap_load, commit, cap_ok;
  logic [3:0]        code_in;

  logic [3:0]        mem [DEPTH];
  logic [PTR_W-1:0]  wptr, rptr, rptr_nx;
  logic [PTR_W:0]    cnt_nx;
  logic              full, push, pop;

  function automatic logic onehot4(input logic [3:0] v);
    return (v != 4'd0) && ((v & (v - 4'd1)) == 4'd0);
  endfunction

  function automatic logic [1:0] idx4(input logic [3:0] v);
    case (v)
      4'b0010: return 2'd1;
      4'b0100: return 2'd2;
      4'b1000: return 2'd3;
      default: return 2'd0;
    endcase
  endfunction

  function automatic logic [3:0] decode(input logic [1:0] r, input logic [1:0] c);
    case ({r, c})
      4'h0: return 4'h1;  4'h1: return 4'h2;  4'h2: return 4'h3;  4'h3: return 4'hA;
      4'h4: return 4'h4;  4'h5: return 4'h5;  4'h6: return 4'h6;  4'h7: return 4'hB;
      4'h8: return 4'h7;  4'h9: return 4'h8;  4'hA: return 4'h9;  4'hB: return 4'hC;
      4'hC: return 4'hE;  4'hD: return 4'h0;  4'hE: return 4'hF;  default: return 4'hD;
    endcase
  endfunction

  // ---------------- capture FSM ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:     if (col != 4'd0) state_nx = HELD;
      HELD:     if (key_en) state_nx = WAIT_REL;
                else if (col == 4'd0 && zero_seen) state_nx = IDLE;
      WAIT_REL: if (col == 4'd0) state_nx = IDLE;
      default:  state_nx = IDLE;
    endcase
  end

  always_comb begin
    cap_load = (state == IDLE) && (col != 4'd0);
    commit   = (state == HELD) && key_en;
  end

  // zero_seen remembers one released cycle in HELD so a second one aborts
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cap_row   <= 4'd0;
      cap_col   <= 4'd0;
      zero_seen <= 1'b0;
    end else begin
      if (cap_load) begin
        cap_row <= row;
        cap_col <= col;
      end
      zero_seen <= (state == HELD) && !key_en && (col == 4'd0);
    end
  end

  assign cap_ok  = onehot4(cap_row) && onehot4(cap_col);
  assign code_in = decode(idx4(cap_row), idx4(cap_col));

  // ---------------- FIFO ----------------
  assign key_valid = (count != '0);
  assign full      = (count == DEPTH_C);
  assign pop       = key_valid && key_ready;
  // a pop in the same cycle frees the slot, so a full FIFO still accepts
  assign push      = commit && cap_ok && (!full || pop);
  assign rptr_nx   = pop ? rptr + PTR_W'(1) : rptr;

  always_comb begin
    cnt_nx = count;
    case ({push, pop})
      2'b10:   cnt_nx = count + 1'b1;
      2'b01:   cnt_nx = count - 1'b1;
      default: cnt_nx = count;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= code_in;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr     <= '0;
      rptr     <= '0;
      count    <= '0;
      key_code <= 4'd0;
      overflow <= 1'b0;
      bad_key  <= 1'b0;
    end else begin
      if (push) wptr <= wptr + PTR_W'(1);
      rptr  <= rptr_nx;
      count <= cnt_nx;
      // registered head: the entry being written this cycle bypasses mem
      if (cnt_nx != '0)
        key_code <= (push && rptr_nx == wptr) ? code_in : mem[rptr_nx];
      overflow <= (commit && cap_ok && full && !pop) || (overflow && !clr_flags);
      bad_key  <= (commit && !cap_ok) || (bad_key && !clr_flags);
    end
  end

endmodule

// File: tb/tb_keypad_key_fifo.sv
module tb_keypad_key_fifo;
  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] row, col;
  logic       key_en, key_ready, clr_flags;
  logic       key_valid, overflow, bad_key;
  logic [3:0] key_code;
  logic [2:0] count;

  int         vectors = 0;
  int         miscompares = 0;
  logic [3:0] exp_q [$];
  logic       exp_ovf = 1'b0;

  keypad_key_fifo #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .row(row), .col(col), .key_en(key_en),
    .key_valid(key_valid), .key_code(key_code), .key_ready(key_ready),
    .count(count), .overflow(overflow), .bad_key(bad_key), .clr_flags(clr_flags)
  );

  always #5 clk = ~clk;

  task automatic test_reset();
    rst_n = 1'b0; row = 4'd0; col = 4'd0; key_en = 1'b0; key_ready = 1'b0; clr_flags = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    vectors++; if (key_valid !== 1'b0) begin miscompares++; $display("FAIL reset_valid got %b want 0", key_valid); end
    vectors++; if (key_code !== 4'd0) begin miscompares++; $display("FAIL reset_code got %h want 0", key_code); end
    vectors++; if (count !== 3'd0) begin miscompares++; $display("FAIL reset_count got %0d want 0", count); end
    vectors++; if ({overflow, bad_key} !== 2'b00) begin miscompares++; $display("FAIL reset_flags got %b want 00", {overflow, bad_key}); end
  endtask

  // Press row r / column c; commit one cycle after capture. With pop_same,
  // key_ready is asserted during the commit cycle.
  task automatic press(input int r, input int c, input logic [3:0] code, input bit pop_same);
    bit will_pop;
    @(negedge clk);
    row = 4'(1 << r); col = 4'(1 << c);
    @(negedge clk);
    key_en = 1'b1;
    will_pop = pop_same && (exp_q.size() > 0);
    if (pop_same) key_ready = 1'b1;
    if (will_pop) begin
      vectors++; if (key_code !== exp_q[0]) begin miscompares++; $display("FAIL pop_head got %h want %h", key_code, exp_q[0]); end
    end
    @(negedge clk);
    key_en = 1'b0; key_ready = 1'b0; row = 4'd0; col = 4'd0;
    if (will_pop) void'(exp_q.pop_front());
    if (exp_q.size() < DEPTH) exp_q.push_back(code);
    else exp_ovf = 1'b1;
    vectors++; if (count !== 3'(exp_q.size())) begin miscompares++; $display("FAIL press_count got %0d want %0d", count, exp_q.size()); end
    vectors++; if (overflow !== exp_ovf) begin miscompares++; $display("FAIL press_overflow got %b want %b", overflow, exp_ovf); end
    vectors++; if (key_valid !== 1'b1) begin miscompares++; $display("FAIL press_valid got %b want 1", key_valid); end
    vectors++; if (key_code !== exp_q[0]) begin miscompares++; $display("FAIL press_head got %h want %h", key_code, exp_q[0]); end
    @(negedge clk);
  endtask

  // Back-to-back pops with key_ready held high; bounded by DEPTH+2 cycles.
  task automatic drain();
    for (int i = 0; i < DEPTH + 2 && exp_q.size() > 0; i++) begin
      vectors++; if (key_valid !== 1'b1) begin miscompares++; $display("FAIL drain_valid got %b want 1", key_valid); end
      vectors++; if (key_code !== exp_q[0]) begin miscompares++; $display("FAIL drain_code got %h want %h", key_code, exp_q[0]); end
      key_ready = 1'b1;
      @(negedge clk);
      void'(exp_q.pop_front());
    end
    key_ready = 1'b0;
    vectors++; if (exp_q.size() != 0) begin miscompares++; $display("FAIL drain_timeout left %0d want 0", exp_q.size()); end
    vectors++; if (key_valid !== 1'b0) begin miscompares++; $display("FAIL drain_empty got %b want 0", key_valid); end
    vectors++; if (count !== 3'd0) begin miscompares++; $display("FAIL drain_count got %0d want 0", count); end
  endtask

  task automatic test_single_key();
    press(1, 2, 4'h6, 1'b0);
    repeat (3) begin
      @(negedge clk);
      vectors++; if (key_code !== 4'h6 || key_valid !== 1'b1) begin miscompares++; $display("FAIL hold_code got %h/%b want 6/1", key_code, key_valid); end
    end
    drain();
  endtask

  task automatic test_overflow();
    press(0, 0, 4'h1, 1'b0);
    press(1, 1, 4'h5, 1'b0);
    press(2, 2, 4'h9, 1'b0);
    press(3, 3, 4'hD, 1'b0);
    press(3, 1, 4'h0, 1'b0);
    drain();
    clr_flags = 1'b1;
    @(negedge clk);
    clr_flags = 1'b0; exp_ovf = 1'b0;
    vectors++; if (overflow !== 1'b0) begin miscompares++; $display("FAIL ovf_clear got %b want 0", overflow); end
  endtask

  task automatic test_bad_key();
    @(negedge clk);
    row = 4'b0010; col = 4'b0110;
    @(negedge clk);
    key_en = 1'b1;
    @(negedge clk);
    key_en = 1'b0; row = 4'd0; col = 4'd0;
    vectors++; if (bad_key !== 1'b1) begin miscompares++; $display("FAIL bad_set got %b want 1", bad_key); end
    vectors++; if (count !== 3'd0 || overflow !== 1'b0) begin miscompares++; $display("FAIL bad_count got %0d/%b want 0/0", count, overflow); end
    @(negedge clk);
    clr_flags = 1'b1;
    @(negedge clk);
    clr_flags = 1'b0;
    vectors++; if (bad_key !== 1'b0) begin miscompares++; $display("FAIL bad_clear got %b want 0", bad_key); end
  endtask

  task automatic test_full_push_pop();
    press(0, 0, 4'h1, 1'b0);
    press(0, 1, 4'h2, 1'b0);
    press(0, 2, 4'h3, 1'b0);
    press(1, 0, 4'h4, 1'b0);
    press(0, 3, 4'hA, 1'b1);
    drain();
  endtask

  task automatic test_ignored_commits();
    @(negedge clk);
    key_en = 1'b1;
    @(negedge clk);
    key_en = 1'b0;
    vectors++; if (count !== 3'd0 || {overflow, bad_key} !== 2'b00) begin miscompares++; $display("FAIL idle_en got %0d/%b want 0/00", count, {overflow, bad_key}); end
    row = 4'b0100; col = 4'b0010;
    @(negedge clk);
    key_en = 1'b1;
    @(negedge clk);
    key_en = 1'b0;
    exp_q.push_back(4'h8);
    @(negedge clk);
    key_en = 1'b1;
    @(negedge clk);
    key_en = 1'b0; row = 4'd0; col = 4'd0;
    vectors++; if (count !== 3'd1 || {overflow, bad_key} !== 2'b00) begin miscompares++; $display("FAIL waitrel_en got %0d/%b want 1/00", count, {overflow, bad_key}); end
    @(negedge clk);
    row = 4'b0001; col = 4'b0001;
    @(negedge clk);
    col = 4'd0; row = 4'd0;
    repeat (2) @(negedge clk);
    key_en = 1'b1;
    @(negedge clk);
    key_en = 1'b0;
    vectors++; if (count !== 3'd1 || {overflow, bad_key} !== 2'b00) begin miscompares++; $display("FAIL bounce_en got %0d/%b want 1/00", count, {overflow, bad_key}); end
    drain();
  endtask

  task automatic test_async_reset();
    press(0, 1, 4'h2, 1'b0);
    @(negedge clk);
    row = 4'b0100; col = 4'b0001;
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    vectors++; if (key_valid !== 1'b0 || count !== 3'd0) begin miscompares++; $display("FAIL arst_fifo got %b/%0d want 0/0", key_valid, count); end
    vectors++; if (key_code !== 4'd0) begin miscompares++; $display("FAIL arst_code got %h want 0", key_code); end
    row = 4'd0; col = 4'd0;
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    key_en = 1'b1;
    @(negedge clk);
    key_en = 1'b0;
    @(negedge clk);
    vectors++; if (count !== 3'd0 || key_valid !== 1'b0 || {overflow, bad_key} !== 2'b00) begin miscompares++; $display("FAIL arst_commit got %0d/%b/%b want 0/0/00", count, key_valid, {overflow, bad_key}); end
  endtask

  initial begin
    test_reset();
    test_single_key();
    test_overflow();
    test_bad_key();
    test_full_push_pop();
    test_ignored_commits();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
